g2b_ptr_sync: RTL
=================

G2B_PTR_SYNC -- requirements
Module: g2b_ptr_sync

Interface
REQ-001 The module SHALL take parameter `WPTR_WIDTH`, default 8 (from the `parameters.vh` macro), as the pointer width W.
REQ-002 The module SHALL have `rclk`, input, 1 bit, as the read-domain clock; there is one clock.
REQ-003 The module SHALL have `rrst_n`, input, 1 bit, as the reset: asynchronous, active-low.
REQ-004 The module SHALL have `wptr_gray`, input, W bits: write pointer in Gray code, asynchronous to `rclk`.
REQ-005 The module SHALL have `rptr_bin`, input, W bits: local read pointer in binary, synchronous to `rclk`.
REQ-006 The module SHALL have `err_clr`, input, 1 bit: single-cycle clear of `ptr_err`.
REQ-007 The module SHALL have `wptr_gray_sync`, output, W bits: the second synchronizer stage.
REQ-008 The module SHALL have `wptr_bin`, output, W bits: registered decoded binary write pointer.
REQ-009 The module SHALL have `wptr_vld`, output, 1 bit: decoded pointer is meaningful.
REQ-010 The module SHALL have `ptr_err`, output, 1 bit: sticky multi-bit-change error.
REQ-011 The module SHALL have `fill_level`, output, W bits: `wptr_bin` minus `rptr_bin`, modulo 2^W.
REQ-012 The module SHALL have `empty`, output, 1 bit: no readable entries.

Function
REQ-013 The design SHALL sample `wptr_gray` into sync stage 1 on each `rclk` rising edge, then copy stage 1 into stage 2 (`wptr_gray_sync`) on the next edge.
- No logic is permitted between the two stages.
REQ-014 The Gray-to-binary decode SHALL take stage 2 as input:
- b[W-1] = g[W-1]
- b[i] = b[i+1] XOR g[i], for i = W-2 down to 0
- The result SHALL be registered into `wptr_bin`.
REQ-015 Latency SHALL be fixed: a value stable on `wptr_gray` before edge k SHALL appear on `wptr_gray_sync` after edge k+1 and on `wptr_bin` after edge k+2.
REQ-016 A 2-bit saturating counter SHALL count rising edges after reset release.
- `wptr_vld` SHALL assert after the 3rd edge and stay 1 until the next reset.
REQ-017 A previous-sample register SHALL hold the prior value of stage 2.
- When `wptr_vld`=1 and the XOR of stage 2 with the prior sample has more than one bit set, `ptr_err` SHALL be 1 after the next edge.
REQ-018 `ptr_err` SHALL be sticky.
- `err_clr`=1 SHALL clear it on the next edge.
- If a new error occurs in the same cycle as `err_clr`, set SHALL win and `ptr_err` stays 1.
REQ-019 A zero-bit or one-bit change, including the wrap from Gray 0x80 to 0x00 for W=8, SHALL NOT set `ptr_err`.
REQ-020 `fill_level` SHALL be combinational: (`wptr_bin` - `rptr_bin`) mod 2^W.
- No saturation; wrap-around SHALL follow modular arithmetic.
REQ-021 `empty` SHALL equal (`wptr_bin` == `rptr_bin`) OR NOT `wptr_vld`.
REQ-022 The block SHALL NOT backpressure or gate its inputs; every clock edge SHALL sample.

Reset
REQ-023 `rrst_n`=0 SHALL immediately, without waiting for a clock edge, drive the following to 0:
- both sync stages
- the previous-sample register
- `wptr_bin`
- the valid counter
- `wptr_vld`
- `ptr_err`
REQ-024 During reset, `fill_level` SHALL equal 0 - `rptr_bin` mod 2^W, and `empty` SHALL be 1.
REQ-025 Reset asserted mid-operation SHALL discard all in-flight samples.
- After release, `wptr_vld` SHALL re-qualify over 3 edges.
REQ-026 Reset release SHALL be treated as synchronous to `rclk` by the upstream reset synchronizer; the block itself SHALL NOT resynchronize it.

Verification
REQ-027 Reset check (stimulus -> response):
- Assert `rrst_n`=0 with `wptr_gray`=0x3F -> all registers 0, `empty`=1, `wptr_vld`=0.
- Release -> `wptr_vld`=1 after the 3rd edge.
REQ-028 Sequential pointer steps (stimulus -> response):
- Drive `wptr_gray` 0x00, 0x01, 0x03, 0x02, one per cycle -> `wptr_bin` 0x00, 0x01, 0x02, 0x03, each 3 edges later.
- `ptr_err` stays 0.
REQ-029 Wrap with `rptr_bin`=0xFE (stimulus -> response):
- `wptr_gray` 0x80 -> `wptr_bin`=0xFF, `fill_level`=0x01.
- Then `wptr_gray` 0x00 -> `wptr_bin`=0x00, `fill_level`=0x02, `ptr_err`=0.
REQ-030 Multi-bit error after `wptr_vld`=1 (stimulus -> response):
- `wptr_gray` 0x00 -> 0x03 -> `ptr_err`=1 and stays 1.
- `err_clr` pulse -> 0.
- A second 0x03 -> 0x00 jump coinciding with `err_clr` -> `ptr_err` remains 1.
REQ-031 Mid-operation reset (stimulus -> response):
- `wptr_bin`=0x2A (`wptr_gray`=0x3F), then `rrst_n` low between edges -> `wptr_bin`=0x00 and `wptr_vld`=0 at once, with no clock edge.
REQ-032 Empty check (stimulus -> response):
- `wptr_bin`=0x10 with `rptr_bin`=0x10 -> `empty`=1, `fill_level`=0x00.
- `rptr_bin`=0x0C -> `empty`=0, `fill_level`=0x04.

Source files
------------

// File: rtl/g2b_ptr_sync.sv
// Purpose : brings a Gray-coded write pointer into the read clock domain, decodes it
//           to binary, qualifies it after reset and flags illegal multi-bit Gray steps.
// Latency : wptr_gray -> wptr_gray_sync 2 rclk edges, -> wptr_bin 3 rclk edges.
// Backpr. : none; every rclk edge samples, no input is ever gated or stalled.
//
// Ports:
//   rclk / rrst_n   read-domain clock, asynchronous active-low reset
//   wptr_gray       write pointer in Gray code, asynchronous to rclk
//   rptr_bin        local binary read pointer, synchronous to rclk
//   err_clr         single-cycle clear of the sticky ptr_err flag
//   wptr_gray_sync  second synchronizer stage
//   wptr_bin        registered binary decode of wptr_gray_sync
//   wptr_vld        decoded pointer is meaningful (3 edges after reset release)
//   ptr_err         sticky flag: a synchronized sample moved by more than one bit
//   fill_level      (wptr_bin - rptr_bin) mod 2^W, combinational
//   empty           no readable entries, or the write pointer is not yet qualified
module g2b_ptr_sync #(
  parameter int WPTR_WIDTH = 8
) (
  input  logic                  rclk,
  input  logic                  rrst_n,
  input  logic [WPTR_WIDTH-1:0] wptr_gray,
  input  logic [WPTR_WIDTH-1:0] rptr_bin,
  input  logic                  err_clr,
  output logic [WPTR_WIDTH-1:0] wptr_gray_sync,
  output logic [WPTR_WIDTH-1:0] wptr_bin,
  output logic                  wptr_vld,
  output logic                  ptr_err,
  output logic [WPTR_WIDTH-1:0] fill_level,
  output logic                  empty
);

  localparam logic [WPTR_WIDTH-1:0] ONE = {{(WPTR_WIDTH-1){1'b0}}, 1'b1};

  // Two-flop synchronizer; nothing may sit between the stages.
  logic [WPTR_WIDTH-1:0] r_sync1;
  logic [WPTR_WIDTH-1:0] r_sync2;
  // Prior value of stage 2, used to measure how many bits moved per edge.
  logic [WPTR_WIDTH-1:0] r_prev;
  logic [WPTR_WIDTH-1:0] r_wptr_bin;
  logic [1:0]            r_vld_cnt;
  logic                  r_vld;
  logic                  r_ptr_err;

  logic [WPTR_WIDTH-1:0] w_dec;
  logic [WPTR_WIDTH-1:0] w_diff;
  logic                  w_multi_bit;
  logic                  w_err_set;

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= wptr_gray;
      r_sync2 <= r_sync1;
    end
  end

  // Binary bit i is the XOR of all Gray bits from the MSB down to i; this is the
  // b[i] = b[i+1] ^ g[i] recurrence unrolled, without a combinational chain
  // through the result vector itself.
  always_comb begin
    w_dec = '0;
    for (int i = 0; i < WPTR_WIDTH; i++) begin
      w_dec[i] = ^(r_sync2 >> i);
    end
  end

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      r_wptr_bin <= '0;
      r_prev     <= '0;
    end else begin
      r_wptr_bin <= w_dec;
      r_prev     <= r_sync2;
    end
  end

  // Valid qualification: the synchronizer and decode pipeline hold reset zeros,
  // not real samples, until three edges have passed since release.
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      r_vld_cnt <= 2'd0;
      r_vld     <= 1'b0;
    end else begin
      if (r_vld_cnt != 2'd3) begin
        r_vld_cnt <= r_vld_cnt + 2'd1;
      end
      if (r_vld_cnt == 2'd2) begin
        r_vld <= 1'b1;
      end
    end
  end

  // More than one bit set <=> clearing the lowest set bit leaves something behind.
  // Gated by r_vld so the step from reset zeros to the first real sample is ignored.
  assign w_diff      = r_sync2 ^ r_prev;
  assign w_multi_bit = |(w_diff & (w_diff - ONE));
  assign w_err_set   = r_vld & w_multi_bit;

  // Sticky error: a new error in the same cycle as err_clr keeps the flag set.
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      r_ptr_err <= 1'b0;
    end else if (w_err_set) begin
      r_ptr_err <= 1'b1;
    end else if (err_clr) begin
      r_ptr_err <= 1'b0;
    end
  end

  assign wptr_gray_sync = r_sync2;
  assign wptr_bin       = r_wptr_bin;
  assign wptr_vld       = r_vld;
  assign ptr_err        = r_ptr_err;

  // Plain modular subtraction; wrap-around of either pointer is handled for free.
  assign fill_level = r_wptr_bin - rptr_bin;
  assign empty      = (r_wptr_bin == rptr_bin) | ~r_vld;

endmodule
